// File: rtl/demux_1to4_32bit_buf_pkg.sv
// Shared constants for the buffered 1-to-4 demultiplexer.
// Channel indices map in_sel values onto output slots A..D.
// Slot state encoding is used by the per-slot EMPTY/FULL FSM.
package demux_pkg;

  localparam logic [1:0] CH_A = 2'd0;
  localparam logic [1:0] CH_B = 2'd1;
  localparam logic [1:0] CH_C = 2'd2;
  localparam logic [1:0] CH_D = 2'd3;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_e;

endpackage

// File: rtl/demux_1to4_32bit_buf_if.sv
// Bus bundle for the buffered 1-to-4 demultiplexer: one input stream, four output slots.
// slave modport is the demux view, master modport is the producer/consumer view.
// cnt_out exists only when DEMUX_STATS_EN is defined.
interface demux_1to4_32bit_buf_if #(
  parameter int WIDTH = 32
`ifdef DEMUX_STATS_EN
  , parameter int CNT_W = 16
`endif
);

  logic             in_valid;
  logic             in_ready;
  logic [1:0]       in_sel;
  logic [WIDTH-1:0] in_data;
  logic [WIDTH-1:0] outA;
  logic [WIDTH-1:0] outB;
  logic [WIDTH-1:0] outC;
  logic [WIDTH-1:0] outD;
  logic [3:0]       out_valid;
  logic [3:0]       out_ready;
`ifdef DEMUX_STATS_EN
  logic [4*CNT_W-1:0] cnt_out;
`endif

  modport slave (
    input  in_valid, in_sel, in_data, out_ready,
    output in_ready, outA, outB, outC, outD, out_valid
`ifdef DEMUX_STATS_EN
    , output cnt_out
`endif
  );

  modport master (
    output in_valid, in_sel, in_data, out_ready,
    input  in_ready, outA, outB, outC, outD, out_valid
`ifdef DEMUX_STATS_EN
    , input cnt_out
`endif
  );

endinterface

// File: rtl/demux_1to4_32bit_buf_slot.sv
// One-entry output buffer with EMPTY/FULL FSM for one demux channel.
// Latency: word written at edge N is presented with o_valid after edge N.
// Backpressure: o_can_accept = ~full | i_rd_ready, allowing 1 word/cycle streaming.
module demux_slot
  import demux_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_wr_en,
  input  logic [WIDTH-1:0] i_wr_data,
  input  logic             i_rd_ready,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data,
  output logic             o_can_accept
);

  slot_state_e      r_state;
  logic [WIDTH-1:0] r_data;

  // Slot FSM: load on write, empty on drain without refill; data held while stalled.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= SLOT_EMPTY;
      r_data  <= '0;
    end else begin
      case (r_state)
        SLOT_EMPTY: begin
          if (i_wr_en) begin
            r_state <= SLOT_FULL;
            r_data  <= i_wr_data;
          end
        end
        SLOT_FULL: begin
          // A write while full is only possible when the consumer takes the old word.
          if (i_wr_en) begin
            r_data <= i_wr_data;
          end else if (i_rd_ready) begin
            r_state <= SLOT_EMPTY;
          end
        end
        default: r_state <= SLOT_EMPTY;
      endcase
    end
  end

  assign o_valid      = (r_state == SLOT_FULL);
  assign o_data       = r_data;
  assign o_can_accept = (r_state == SLOT_EMPTY) | i_rd_ready;

endmodule

// File: rtl/demux_1to4_32bit_buf.sv
// Buffered 1-to-4 demux: steers each accepted word into one of four single-entry slots.
// Latency: one cycle from input acceptance to out_valid on the selected slot.
// Backpressure: in_ready follows the addressed slot only; optional per-channel counters via DEMUX_STATS_EN.
module demux_1to4_32bit_buf
  import demux_pkg::*;
#(
  parameter int WIDTH = 32
`ifdef DEMUX_STATS_EN
  , parameter int CNT_W = 16
`endif
) (
  input  logic                  Clk,
  input  logic                  Reset_n,
  demux_1to4_32bit_buf_if.slave bus
);

  logic [3:0]       w_wr_en;
  logic [3:0]       w_valid;
  logic [3:0]       w_can_accept;
  logic [WIDTH-1:0] w_data [4];
  logic             w_in_ready;

  // No input is accepted while reset is asserted, so an in-flight word is dropped.
  assign w_in_ready   = Reset_n & w_can_accept[bus.in_sel];
  assign bus.in_ready = w_in_ready;

  for (genvar g = 0; g < 4; g++) begin : g_slot
    assign w_wr_en[g] = bus.in_valid & w_in_ready & (bus.in_sel == 2'(g));

    demux_slot #(.WIDTH(WIDTH)) u_slot (
      .i_clk        (Clk),
      .i_rst_n      (Reset_n),
      .i_wr_en      (w_wr_en[g]),
      .i_wr_data    (bus.in_data),
      .i_rd_ready   (bus.out_ready[g]),
      .o_valid      (w_valid[g]),
      .o_data       (w_data[g]),
      .o_can_accept (w_can_accept[g])
    );
  end

  assign bus.out_valid = w_valid;
  assign bus.outA      = w_data[CH_A];
  assign bus.outB      = w_data[CH_B];
  assign bus.outC      = w_data[CH_C];
  assign bus.outD      = w_data[CH_D];

`ifdef DEMUX_STATS_EN
  logic [CNT_W-1:0] r_cnt [4];

  // Per-channel delivered-word counters, wrapping modulo 2^CNT_W.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      for (int i = 0; i < 4; i++) r_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (w_valid[i] & bus.out_ready[i]) r_cnt[i] <= r_cnt[i] + 1'b1;
      end
    end
  end

  for (genvar g = 0; g < 4; g++) begin : g_cnt
    assign bus.cnt_out[g*CNT_W +: CNT_W] = r_cnt[g];
  end
`endif

endmodule

// File: tb/tb_demux_1to4_32bit_buf.sv
// Directed bench for the buffered 1-to-4 demux: table-driven routing/backpressure
// vectors plus hand-written reset, streaming, mid-op reset and counter sequences.
module tb_demux_1to4_32bit_buf;
  import demux_pkg::*;

  localparam int WIDTH = 32;
  localparam int CNT_W = 4;

  logic clk;
  logic rst_n;

`ifdef DEMUX_STATS_EN
  demux_1to4_32bit_buf_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();
  demux_1to4_32bit_buf #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .Clk(clk), .Reset_n(rst_n), .bus(bus.slave));
`else
  demux_1to4_32bit_buf_if #(.WIDTH(WIDTH)) bus ();
  demux_1to4_32bit_buf #(.WIDTH(WIDTH)) dut (
    .Clk(clk), .Reset_n(rst_n), .bus(bus.slave));
`endif

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        vld;
    logic [1:0]  sel;
    logic [31:0] dat;
    logic [3:0]  ordy;
    logic        exp_rdy;
    logic [3:0]  exp_ov;
    logic [1:0]  chk;
    logic [31:0] exp_dat;
  } vec_t;

  vec_t tbl [9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] out_of(input logic [1:0] ch);
    case (ch)
      CH_A:    return bus.outA;
      CH_B:    return bus.outB;
      CH_C:    return bus.outC;
      default: return bus.outD;
    endcase
  endfunction

  task automatic drive(input logic v, input logic [1:0] s, input logic [31:0] d, input logic [3:0] r);
    bus.in_valid  = v;
    bus.in_sel    = s;
    bus.in_data   = d;
    bus.out_ready = r;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    //             vld   sel   data          ordy     rdy   ov       chk   exp data
    tbl[0] = '{1'b1, CH_A, 32'h11111111, 4'b1111, 1'b1, 4'b0001, CH_A, 32'h11111111};
    tbl[1] = '{1'b1, CH_B, 32'h22222222, 4'b1111, 1'b1, 4'b0010, CH_B, 32'h22222222};
    tbl[2] = '{1'b1, CH_C, 32'h33333333, 4'b1111, 1'b1, 4'b0100, CH_C, 32'h33333333};
    tbl[3] = '{1'b1, CH_D, 32'h44444444, 4'b1111, 1'b1, 4'b1000, CH_D, 32'h44444444};
    // Slot B fills and then stalls; C still flows; B drains when its consumer returns.
    tbl[4] = '{1'b1, CH_B, 32'hBBBB0001, 4'b1101, 1'b1, 4'b0010, CH_B, 32'hBBBB0001};
    tbl[5] = '{1'b1, CH_B, 32'hDEADBEEF, 4'b1101, 1'b0, 4'b0010, CH_B, 32'hBBBB0001};
    tbl[6] = '{1'b1, CH_C, 32'hCAFEF00D, 4'b1101, 1'b1, 4'b0110, CH_C, 32'hCAFEF00D};
    tbl[7] = '{1'b0, CH_B, 32'h00000000, 4'b1101, 1'b0, 4'b0010, CH_B, 32'hBBBB0001};
    tbl[8] = '{1'b0, CH_B, 32'h00000000, 4'b1111, 1'b1, 4'b0000, CH_B, 32'hBBBB0001};

    // Reset: one cycle low with all consumers stalled.
    rst_n = 1'b0;
    drive(1'b0, CH_A, 32'h0, 4'b0000);
    step();
    chk("rst_out_valid", {28'd0, bus.out_valid}, 32'h0);
    chk("rst_outA", bus.outA, 32'h0);
    chk("rst_outB", bus.outB, 32'h0);
    chk("rst_outC", bus.outC, 32'h0);
    chk("rst_outD", bus.outD, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_in_ready", {31'd0, bus.in_ready}, 32'h1);

    // Routing and backpressure table.
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      drive(tbl[i].vld, tbl[i].sel, tbl[i].dat, tbl[i].ordy);
      #1;
      chk($sformatf("vec%0d_in_ready", i), {31'd0, bus.in_ready}, {31'd0, tbl[i].exp_rdy});
      step();
      chk($sformatf("vec%0d_out_valid", i), {28'd0, bus.out_valid}, {28'd0, tbl[i].exp_ov});
      chk($sformatf("vec%0d_data", i), out_of(tbl[i].chk), tbl[i].exp_dat);
    end
    // in_ready for a free slot while B is stalled, independent of in_valid.
    @(negedge clk);
    drive(1'b1, CH_B, 32'h5, 4'b0000);
    step();
    @(negedge clk);
    drive(1'b0, CH_C, 32'h0, 4'b0000);
    #1;
    chk("bp_sel2_ready", {31'd0, bus.in_ready}, 32'h1);
    bus.in_sel = CH_B;
    #1;
    chk("bp_sel1_blocked", {31'd0, bus.in_ready}, 32'h0);
    bus.out_ready = 4'b0010;
    step();

    // Streaming: 8 back-to-back words into D.
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      drive(1'b1, CH_D, 32'hD0000000 + 32'(k), 4'b1000);
      #1;
      chk($sformatf("stream%0d_in_ready", k), {31'd0, bus.in_ready}, 32'h1);
      step();
      chk($sformatf("stream%0d_valid", k), {28'd0, bus.out_valid}, 32'h8);
      chk($sformatf("stream%0d_outD", k), bus.outD, 32'hD0000000 + 32'(k));
    end
    @(negedge clk);
    drive(1'b0, CH_D, 32'h0, 4'b1000);
    step();
    chk("stream_drained", {28'd0, bus.out_valid}, 32'h0);

    // Mid-operation reset with A and C full; word offered during reset is dropped.
    @(negedge clk);
    drive(1'b1, CH_A, 32'hAAAA0001, 4'b0000);
    step();
    @(negedge clk);
    drive(1'b1, CH_C, 32'hCCCC0001, 4'b0000);
    step();
    chk("midrst_pre_valid", {28'd0, bus.out_valid}, 32'h5);
    @(negedge clk);
    rst_n = 1'b0;
    drive(1'b1, CH_B, 32'h99999999, 4'b0000);
    #1;
    chk("midrst_in_ready", {31'd0, bus.in_ready}, 32'h0);
    step();
    chk("midrst_valid", {28'd0, bus.out_valid}, 32'h0);
    chk("midrst_outA", bus.outA, 32'h0);
    chk("midrst_outC", bus.outC, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b0, CH_B, 32'h0, 4'b0000);
    step();
    chk("midrst_dropped", {28'd0, bus.out_valid}, 32'h0);
    chk("midrst_outB", bus.outB, 32'h0);

`ifdef DEMUX_STATS_EN
    // Counter wrap: 17 deliveries on channel B with CNT_W=4.
    @(negedge clk);
    rst_n = 1'b0;
    step();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("cnt_after_reset", {16'd0, bus.cnt_out}, 32'h0);
    for (int k = 0; k < 17; k++) begin
      @(negedge clk);
      drive(1'b1, CH_B, 32'hB0000000 + 32'(k), 4'b0010);
      step();
    end
    @(negedge clk);
    drive(1'b0, CH_B, 32'h0, 4'b0010);
    step();
    chk("cnt_B_wrap", {28'd0, bus.cnt_out[7:4]}, 32'h1);
    chk("cnt_others", {20'd0, bus.cnt_out[15:8], bus.cnt_out[3:0]}, 32'h0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
